// File: rtl/math_pipelined_sched_if.sv
// Request/response bundle between client logic and math_pipelined_sched.
//   req_valid/req_ready  per-requester handshake (ready is a one-hot accept strobe)
//   req_op/a/b/c         packed per-requester payload, slice i = [3i+:3] / [WIDTH*i+:WIDTH]
//   resp_valid/ready     single shared response channel
//   resp_id/data/err     requester index, result (1-bit ops zero-extended), illegal-op flag
// master = client side, slave = scheduler side.
interface math_pipelined_sched_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*3-1:0]     req_op;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*WIDTH-1:0] req_c;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_data;
  logic                     resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/math_pipelined_sched.sv
// Round-robin scheduler sharing one external math_pipelined ALU among NUM_REQ
// requesters. Per op: one-cycle alu_ce load pulse, LATENCY+1 settle cycles with
// operands held, result capture, then a tagged valid/ready response.
// Ports:
//   clk, rst     clock (posedge) and asynchronous active-high reset
//   bus          request/response bundle (slave side)
//   busy         high whenever the scheduler is not idle
//   alu_ce       load strobe to the ALU
//   alu_i1/2/3   registered operands to the ALU, held from load to capture
//   alu_sum..neq ALU result outputs
module math_pipelined_sched #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  math_pipelined_sched_if.slave  bus,
  output logic                   busy,
  output logic                   alu_ce,
  output logic [WIDTH-1:0]       alu_i1,
  output logic [WIDTH-1:0]       alu_i2,
  output logic [WIDTH-1:0]       alu_i3,
  input  logic [WIDTH-1:0]       alu_sum,
  input  logic [WIDTH-1:0]       alu_sub,
  input  logic                   alu_and,
  input  logic                   alu_or,
  input  logic                   alu_xor,
  input  logic                   alu_eq,
  input  logic                   alu_neq
);
  localparam int CNT_W = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RESP} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [2:0]       cur_op;
  logic [CNT_W-1:0] cnt;

  logic             resp_valid_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_err_q;

  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, sel_c;
  logic [WIDTH-1:0] alu_result;

  // Two passes over the requesters: indices >= rr_ptr first, then the wrapped
  // ones, so the first hit is the round-robin winner.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_c     = '0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && bus.req_valid[i] &&
            ((pass == 0) ? (ID_W'(i) >= rr_ptr) : (ID_W'(i) < rr_ptr))) begin
          grant_any = 1'b1;
          grant_id  = ID_W'(i);
          sel_op    = bus.req_op[3*i +: 3];
          sel_a     = bus.req_a[WIDTH*i +: WIDTH];
          sel_b     = bus.req_b[WIDTH*i +: WIDTH];
          sel_c     = bus.req_c[WIDTH*i +: WIDTH];
        end
      end
    end
  end

  // Accept strobe is combinational; gated by rst so it reads 0 during reset.
  always_comb begin
    bus.req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = (state == IDLE) && !rst && grant_any && (grant_id == ID_W'(i));
    end
  end

  always_comb begin
    case (cur_op)
      3'd0:    alu_result = alu_sum;
      3'd1:    alu_result = alu_sub;
      3'd2:    alu_result = WIDTH'(alu_and);
      3'd3:    alu_result = WIDTH'(alu_or);
      3'd4:    alu_result = WIDTH'(alu_xor);
      3'd5:    alu_result = WIDTH'(alu_eq);
      3'd6:    alu_result = WIDTH'(alu_neq);
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      cur_op       <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      alu_ce       <= 1'b0;
      alu_i1       <= '0;
      alu_i2       <= '0;
      alu_i3       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cur_id <= grant_id;
            cur_op <= sel_op;
            alu_i1 <= sel_a;
            alu_i2 <= sel_b;
            alu_i3 <= sel_c;
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            busy   <= 1'b1;
            if (sel_op == OP_ILLEGAL) begin
              // Nothing for the ALU to do: answer with an error immediately.
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_id_q    <= grant_id;
              resp_data_q  <= '0;
              resp_err_q   <= 1'b1;
            end else begin
              state  <= LOAD;
              alu_ce <= 1'b1;
            end
          end
        end
        LOAD: begin
          alu_ce <= 1'b0;
          cnt    <= '0;
          state  <= SETTLE;
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_id_q    <= cur_id;
            resp_data_q  <= alu_result;
            resp_err_q   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_math_pipelined_sched.sv
module tb_math_pipelined_sched;
  localparam int WIDTH = 8, LATENCY = 4, NUM_REQ = 3, ID_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  math_pipelined_sched_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

  logic       busy, alu_ce;
  logic [7:0] alu_i1, alu_i2, alu_i3, alu_sum, alu_sub;
  logic       alu_and, alu_or, alu_xor, alu_eq, alu_neq;

  math_pipelined_sched #(.WIDTH(WIDTH), .LATENCY(LATENCY), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .alu_ce(alu_ce),
    .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_i3(alu_i3),
    .alu_sum(alu_sum), .alu_sub(alu_sub), .alu_and(alu_and), .alu_or(alu_or),
    .alu_xor(alu_xor), .alu_eq(alu_eq), .alu_neq(alu_neq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ALU stand-in: results are only correct once LATENCY edges have passed since
  // the ce edge, and show inverted garbage before that.
  logic [7:0] pa = '0, pb = '0, pc = '0;
  int acnt = 0;
  logic good;
  always @(posedge clk) begin
    if (alu_ce) begin
      pa <= alu_i1; pb <= alu_i2; pc <= alu_i3; acnt <= LATENCY;
    end else if (acnt > 0) begin
      acnt <= acnt - 1;
    end
  end
  always_comb begin
    good    = (acnt == 0);
    alu_sum = good ? pa + pb : ~(pa + pb);
    alu_sub = good ? pa - pb : ~(pa - pb);
    alu_and = (pa[0] & pb[0]) ^ !good;
    alu_or  = (pa[0] | pb[0]) ^ !good;
    alu_xor = (pa[0] ^ pb[0]) ^ !good;
    alu_eq  = (pa == pc) ^ !good;
    alu_neq = (pa != pc) ^ !good;
  end

  function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a, b, c);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return {7'b0, a[0] & b[0]};
      3'd3: return {7'b0, a[0] | b[0]};
      3'd4: return {7'b0, a[0] ^ b[0]};
      3'd5: return {7'b0, a == c};
      3'd6: return {7'b0, a != c};
      default: return 8'h00;
    endcase
  endfunction

  // Transaction-level model: one op in flight, outputs derived from the cycle
  // distance to the accept.
  int cyc = 0;
  logic m_busy = 1'b0;
  int m_t = 0, m_rr = 0, el = 0, g = 0, j = 0;
  logic [2:0] m_op = '0;
  logic [1:0] m_id = '0;
  logic [7:0] m_a = '0, m_b = '0, m_c = '0;
  logic m_legal, e_rv, e_ce;
  logic [NUM_REQ-1:0] e_rdy;

  // Observation log (DUT actuals) for the hand-computed checks.
  int n_resp = 0, ce_cnt = 0, last_acc_cyc = 0, last_ce_cyc = 0, first_rv_cyc = 0, last_hs_cyc = 0;
  logic rv_prev = 1'b0;
  logic [1:0] last_rid = '0;
  logic [7:0] last_rdata = '0;
  logic last_rerr = 1'b0;
  int grant_log[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_alu_ce", alu_ce, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_alu_i1", alu_i1, 0);
      chk("rst_resp_id", bus.resp_id, 0);
      chk("rst_resp_data", bus.resp_data, 0);
      m_busy = 1'b0; m_rr = 0; m_a = '0; m_b = '0; m_c = '0;
      rv_prev = 1'b0;
    end else begin
      el      = cyc - m_t;
      m_legal = (m_op != 3'd7);
      e_rv    = m_busy && (el >= (m_legal ? LATENCY + 3 : 1));
      e_ce    = m_busy && m_legal && (el == 1);
      e_rdy   = '0;
      g       = -1;
      if (!m_busy) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (m_rr + k) % NUM_REQ;
          if (g < 0 && bus.req_valid[j]) begin
            g = j;
            e_rdy[j] = 1'b1;
          end
        end
      end
      chk("busy", busy, m_busy);
      chk("alu_ce", alu_ce, e_ce);
      chk("resp_valid", bus.resp_valid, e_rv);
      chk("req_ready", bus.req_ready, e_rdy);
      chk("alu_i1", alu_i1, m_a);
      chk("alu_i2", alu_i2, m_b);
      chk("alu_i3", alu_i3, m_c);
      if (e_rv) begin
        chk("resp_id", bus.resp_id, m_id);
        chk("resp_data", bus.resp_data, m_legal ? ref_result(m_op, m_a, m_b, m_c) : 8'h00);
        chk("resp_err", bus.resp_err, !m_legal);
      end

      if (alu_ce) begin ce_cnt++; last_ce_cyc = cyc; end
      if (bus.resp_valid && !rv_prev) first_rv_cyc = cyc;
      rv_prev = bus.resp_valid;
      for (int k = 0; k < NUM_REQ; k++)
        if (bus.req_ready[k]) begin last_acc_cyc = cyc; grant_log.push_back(k); end
      if (bus.resp_valid && bus.resp_ready) begin
        n_resp++; last_hs_cyc = cyc;
        last_rid = bus.resp_id; last_rdata = bus.resp_data; last_rerr = bus.resp_err;
      end

      if (m_busy && e_rv && bus.resp_ready) begin
        m_busy = 1'b0;
      end else if (g >= 0) begin
        m_busy = 1'b1; m_t = cyc; m_id = 2'(g);
        m_op = bus.req_op[3*g +: 3];
        m_a  = bus.req_a[8*g +: 8];
        m_b  = bus.req_b[8*g +: 8];
        m_c  = bus.req_c[8*g +: 8];
        m_rr = (g + 1) % NUM_REQ;
      end
    end
  end

  // Requesters drop valid the cycle after their grant.
  task automatic step();
    logic [NUM_REQ-1:0] gr;
    @(negedge clk); gr = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = bus.req_valid & ~gr;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, b, c);
    bus.req_op[3*i +: 3] = op;
    bus.req_a[8*i +: 8]  = a;
    bus.req_b[8*i +: 8]  = b;
    bus.req_c[8*i +: 8]  = c;
    bus.req_valid[i]     = 1'b1;
  endtask

  task automatic wait_resps(input int n, input int budget);
    int target;
    target = n_resp + n;
    for (int k = 0; k < budget && n_resp < target; k++) step();
    if (n_resp < target) begin
      checks++; errors++;
      $display("FAIL resp_timeout actual=%0d required=%0d", n_resp, target);
    end
  endtask

  int ce0, hs1, n0;

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_c = '0;
    bus.resp_ready = 1'b1;
    step(); step();
    rst = 1'b0;

    // 1: ADD timing and result
    ce0 = ce_cnt;
    set_req(0, 3'd0, 8'hF0, 8'h25, 8'h00);
    wait_resps(1, 30);
    chk("t1_data", last_rdata, 8'h15);
    chk("t1_id", last_rid, 0);
    chk("t1_err", last_rerr, 0);
    chk("t1_ce_lat", last_ce_cyc - last_acc_cyc, 1);
    chk("t1_ce_count", ce_cnt - ce0, 1);
    chk("t1_rv_lat", first_rv_cyc - last_acc_cyc, 7);

    // 2: other ops
    set_req(1, 3'd1, 8'h10, 8'h20, 8'h00); wait_resps(1, 30);
    chk("t2_sub_data", last_rdata, 8'hF0); chk("t2_sub_id", last_rid, 1);
    set_req(2, 3'd5, 8'h5A, 8'h00, 8'h5A); wait_resps(1, 30);
    chk("t2_eq_data", last_rdata, 8'h01); chk("t2_eq_id", last_rid, 2);
    set_req(0, 3'd6, 8'h5A, 8'h00, 8'h5A); wait_resps(1, 30);
    chk("t2_neq_data", last_rdata, 8'h00);
    set_req(1, 3'd4, 8'h07, 8'h00, 8'h00); wait_resps(1, 30);
    chk("t2_xor_data", last_rdata, 8'h01);

    // 3: round-robin order
    rst = 1'b1; step(); rst = 1'b0;
    grant_log.delete();
    set_req(0, 3'd0, 8'h01, 8'h01, 8'h00);
    set_req(1, 3'd0, 8'h02, 8'h02, 8'h00);
    set_req(2, 3'd0, 8'h03, 8'h03, 8'h00);
    wait_resps(3, 60);
    chk("t3_n_grants", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("t3_g0", grant_log[0], 0); chk("t3_g1", grant_log[1], 1); chk("t3_g2", grant_log[2], 2);
    end
    grant_log.delete();
    set_req(0, 3'd1, 8'h09, 8'h01, 8'h00);
    set_req(2, 3'd1, 8'h08, 8'h01, 8'h00);
    wait_resps(2, 40);
    chk("t3b_n_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t3b_g0", grant_log[0], 0); chk("t3b_g1", grant_log[1], 2);
    end

    // 4: back-pressure on the response
    bus.resp_ready = 1'b0;
    set_req(1, 3'd0, 8'h01, 8'h02, 8'h00);
    for (int k = 0; k < 20 && !bus.resp_valid; k++) step();
    chk("t4_rv_seen", bus.resp_valid, 1);
    set_req(0, 3'd0, 8'h40, 8'h04, 8'h00);
    step(); step(); step();
    chk("t4_hold_valid", bus.resp_valid, 1);
    chk("t4_hold_data", bus.resp_data, 8'h03);
    chk("t4_hold_id", bus.resp_id, 1);
    chk("t4_no_ready", bus.req_ready, 0);
    bus.resp_ready = 1'b1;
    wait_resps(1, 10);
    hs1 = last_hs_cyc;
    wait_resps(1, 30);
    chk("t4_grant_after_hs", last_acc_cyc - hs1, 1);
    chk("t4_second_data", last_rdata, 8'h44);

    // 5: illegal opcode
    ce0 = ce_cnt;
    set_req(1, 3'd7, 8'hAA, 8'hBB, 8'hCC);
    wait_resps(1, 10);
    chk("t5_err", last_rerr, 1);
    chk("t5_data", last_rdata, 8'h00);
    chk("t5_id", last_rid, 1);
    chk("t5_no_ce", ce_cnt - ce0, 0);
    chk("t5_rv_lat", first_rv_cyc - last_acc_cyc, 1);

    // 6: reset during settle
    set_req(0, 3'd0, 8'h11, 8'h22, 8'h00);
    step();
    set_req(2, 3'd0, 8'h03, 8'h04, 8'h00);
    step(); step();
    chk("t6_busy_before", busy, 1);
    n0 = n_resp;
    rst = 1'b1;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_rv", bus.resp_valid, 0);
    chk("t6_async_ce", alu_ce, 0);
    chk("t6_async_i1", alu_i1, 8'h00);
    step();
    rst = 1'b0;
    wait_resps(1, 30);
    chk("t6_resp_count", n_resp - n0, 1);
    chk("t6_id", last_rid, 2);
    chk("t6_data", last_rdata, 8'h07);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
